dx_rosc_ctrl: RTL and testbench
===============================

# dx_rosc_ctrl

Sequencing controller for the TRNG inverter-chain ring oscillator. It enables the oscillator, selects one of its four chain taps, and waits out a warm-up period. It then samples the free-running `rnd_src` output at a programmable interval and packs the samples into DATA_W-bit words, which it hands to the TRNG post-processing logic over a valid/ready handshake. A stuck-output monitor flags a dead oscillator and can optionally rotate to the next chain tap.

## Interface
Parameters:
- DATA_W, 32, bits per output word (2..64)
- WARMUP, 256, oscillator settle cycles before sampling (>=1, 16-bit)
- STUCK_LIM, 32, consecutive equal samples that declare the source stuck (2..255)

Ports:
- rng_clk  in  1  block clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin generation
- stop  in  1  single-cycle request to halt and discard
- cfg_sel  in  2  chain tap used on start
- cfg_auto_rot  in  1  1 = rotate tap on stuck, 0 = halt on stuck
- cfg_sample_div  in  8  sample interval = cfg_sample_div+1 cycles
- scanmode  in  1  DFT mode
- rnd_src  in  1  raw oscillator output, asynchronous to rng_clk
- rnd_src_en  out  1  oscillator enable
- rnd_src_sel  out  2  oscillator tap select
- data_out  out  DATA_W  assembled random word
- data_valid  out  1  data_out valid
- data_ready  in  1  consumer accepts word
- busy  out  1  state != IDLE
- stuck_err  out  1  sticky stuck indication

## Operation
- `rnd_src` passes through a 2-flop synchronizer. All sampling uses the synchronized bit `s`.
- States: IDLE, WARMUP, COLLECT, HOLD.
- **IDLE**
  - En register = 0.
  - `start` loads sel := cfg_sel, sets en = 1, clears stuck_err and the run counter, and goes to WARMUP.
- **WARMUP**
  - Warm-up counter counts 0..WARMUP-1, then goes to COLLECT.
  - The divider and bit counter are cleared on entry to COLLECT.
- **COLLECT**
  - Divider counts 0..cfg_sample_div. When it equals cfg_sample_div, one sample is taken and the divider wraps to 0.
  - Each sample shifts in: word := {word[DATA_W-2:0], s}. The first sample ends up in the MSB.
  - On the DATA_W-th sample: data_out := the new word, data_valid := 1, go to HOLD.
- **HOLD**
  - The oscillator keeps running. No sampling occurs and data_out is stable.
  - A cycle with data_valid & data_ready is the transfer. On the next edge data_valid := 0, and the state returns to COLLECT with the divider and bit counter cleared.
  - The run counter is preserved across HOLD.
- **Stuck monitor**
  - On each sample: if s equals the previous sample, run++; otherwise run := 1.
  - When run reaches STUCK_LIM:
    - stuck_err := 1, the partial word is discarded, run := 0.
    - If cfg_auto_rot = 1: sel := sel+1 (mod 4, 3 wraps to 0) and go to WARMUP. En stays 1.
    - If cfg_auto_rot = 0: go to IDLE with en = 0.
- **stop** in any non-IDLE state: go to IDLE, en := 0, data_valid := 0, and any pending word is dropped.
  - stop together with start: stop wins (IDLE is held).
  - start while not IDLE is ignored.
- **scanmode = 1**
  - Forces IDLE on the next edge.
  - rnd_src_en = en_reg & ~scanmode (combinational gate), so the oscillator is released immediately.
  - start is ignored while scanmode = 1.
- **Reset values:** rnd_src_en 0, rnd_src_sel 0, data_out 0, data_valid 0, busy 0, stuck_err 0. All counters are 0 and the state is IDLE.
- Reset mid-operation aborts immediately. No state is retained.

## Timing
- All outputs are registered except the scanmode gate on rnd_src_en.
- start sampled at edge N:
  - rnd_src_en = 1, rnd_src_sel = cfg_sel, and busy = 1 after edge N.
  - COLLECT is entered at edge N+WARMUP.
  - The first sample is taken at edge N+WARMUP+cfg_sample_div+1.
- Samples are spaced exactly cfg_sample_div+1 cycles apart.
- data_valid rises at the edge of the DATA_W-th sample.
- Synchronizer latency: a `rnd_src` level present before edge M is visible in s after edge M+1.
- Throughput with data_ready tied high: one word per DATA_W*(cfg_sample_div+1)+1 cycles.
- cfg_* inputs are sampled live. Changing them while busy is not supported except cfg_sample_div, which takes effect at the next divider wrap.

## Test plan
- **Basic word.** DATA_W=8, WARMUP=4, div=0, data_ready=1; rnd_src driven with pattern 1,0,1,1,0,0,1,0 aligned to samples.
  - Expect data_out=8'hB2 and one data_valid pulse at start-edge+4+8.
- **Backpressure.** Same setup with data_ready=0 for 20 cycles.
  - Expect data_valid held, data_out stable, and no new samples.
  - After data_ready=1: transfer, then data_valid=0, and the next word's first sample falls div+1 cycles after the return to COLLECT.
- **Stuck with rotation.** rnd_src=0 constant, STUCK_LIM=32, cfg_sel=3, auto_rot=1.
  - Expect stuck_err=1, rnd_src_sel=0 (wrapped), state WARMUP, rnd_src_en=1, and no data_valid.
- **Stuck with halt.** Same as above but auto_rot=0.
  - Expect IDLE, rnd_src_en=0, busy=0, and stuck_err=1 held until the next start.
- **Stop in HOLD.** Assert stop with data_valid=1.
  - Expect data_valid=0, rnd_src_en=0, busy=0 on the next edge.
  - stop+start in the same cycle: remains IDLE.
- **Scan and reset.** Assert scanmode mid-COLLECT.
  - Expect rnd_src_en=0 in the same cycle and IDLE on the next edge.
  - Deassert rst_n asynchronously mid-WARMUP: expect all outputs 0 immediately.

Source files
------------

// File: rtl/dx_rosc_ctrl.sv
// dx_rosc_ctrl: ring-oscillator TRNG sequencer (warm-up, paced sampling into words, stuck monitor).
// Words leave over valid/ready; sampling pauses while a finished word waits in HOLD.
module dx_rosc_ctrl #(
  parameter int DATA_W    = 32,
  parameter int WARMUP    = 256,
  parameter int STUCK_LIM = 32
) (
  input  logic              rng_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        cfg_sel,
  input  logic              cfg_auto_rot,
  input  logic [7:0]        cfg_sample_div,
  input  logic              scanmode,
  input  logic              rnd_src,
  output logic              rnd_src_en,
  output logic [1:0]        rnd_src_sel,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              stuck_err
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic                meta_q, s_q;
  logic                en_q, en_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   word_q, word_d, word_nx;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                vld_q, vld_d;
  logic                stuck_q, stuck_d;
  logic [15:0]         warm_q, warm_d;
  logic [7:0]          div_q, div_d;
  logic [7:0]          run_q, run_d, run_nx;
  logic [6:0]          bit_q, bit_d;
  logic                prev_q, prev_d;

  // run_q == 0 means no previous sample exists yet, so the first sample opens a run of 1.
  always_comb begin
    word_nx = {word_q[DATA_W-2:0], s_q};
    run_nx  = (run_q != 8'd0 && s_q == prev_q) ? run_q + 8'd1 : 8'd1;
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    sel_d   = sel_q;
    word_d  = word_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    stuck_d = stuck_q;
    warm_d  = warm_q;
    div_d   = div_q;
    run_d   = run_q;
    bit_d   = bit_q;
    prev_d  = prev_q;
    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (start && !stop && !scanmode) begin
          sel_d   = cfg_sel;
          en_d    = 1'b1;
          stuck_d = 1'b0;
          run_d   = 8'd0;
          warm_d  = 16'd0;
          state_d = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (warm_q == 16'(WARMUP - 1)) begin
          div_d   = 8'd0;
          bit_d   = 7'd0;
          state_d = S_COLLECT;
        end else begin
          warm_d = warm_q + 16'd1;
        end
      end
      S_COLLECT: begin
        // >= lets a lowered cfg_sample_div wrap at once instead of running up to 255.
        if (div_q >= cfg_sample_div) begin
          div_d  = 8'd0;
          prev_d = s_q;
          if (run_nx == 8'(STUCK_LIM)) begin
            stuck_d = 1'b1;
            run_d   = 8'd0;
            word_d  = '0;
            bit_d   = 7'd0;
            if (cfg_auto_rot) begin
              sel_d   = sel_q + 2'd1;
              warm_d  = 16'd0;
              state_d = S_WARMUP;
            end else begin
              en_d    = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            run_d  = run_nx;
            word_d = word_nx;
            if (bit_q == 7'(DATA_W - 1)) begin
              dout_d  = word_nx;
              vld_d   = 1'b1;
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (vld_q && data_ready) begin
          vld_d   = 1'b0;
          div_d   = 8'd0;
          bit_d   = 7'd0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop || scanmode) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 2'd0;
      word_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      stuck_q <= 1'b0;
      warm_q  <= 16'd0;
      div_q   <= 8'd0;
      run_q   <= 8'd0;
      bit_q   <= 7'd0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= rnd_src;
      s_q     <= meta_q;
      en_q    <= en_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      stuck_q <= stuck_d;
      warm_q  <= warm_d;
      div_q   <= div_d;
      run_q   <= run_d;
      bit_q   <= bit_d;
      prev_q  <= prev_d;
    end
  end

  assign rnd_src_en  = en_q & ~scanmode;
  assign rnd_src_sel = sel_q;
  assign data_out    = dout_q;
  assign data_valid  = vld_q;
  assign busy        = (state_q != S_IDLE);
  assign stuck_err   = stuck_q;

endmodule

// File: tb/tb_dx_rosc_ctrl.sv
// Directed bench for dx_rosc_ctrl with DATA_W=8, WARMUP=4, STUCK_LIM=32.
module tb_dx_rosc_ctrl;
  logic       rng_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic       cfg_auto_rot = 1'b0;
  logic [7:0] cfg_sample_div = 8'd0;
  logic       scanmode = 1'b0;
  logic       rnd_src = 1'b0;
  logic       rnd_src_en;
  logic [1:0] rnd_src_sel;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       busy;
  logic       stuck_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  dx_rosc_ctrl #(.DATA_W(8), .WARMUP(4), .STUCK_LIM(32)) dut (
    .rng_clk(rng_clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_sel(cfg_sel), .cfg_auto_rot(cfg_auto_rot), .cfg_sample_div(cfg_sample_div),
    .scanmode(scanmode), .rnd_src(rnd_src), .rnd_src_en(rnd_src_en),
    .rnd_src_sel(rnd_src_sel), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .stuck_err(stuck_err)
  );

  always #5 rng_clk = ~rng_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Called just after the edge that enters WARMUP with div=0; samples land at +5..+12.
  task automatic drive_word(input logic [7:0] pat, input string tag);
    step();
    step();
    for (int k = 0; k < 8; k++) begin
      rnd_src = pat[7-k];
      step();
    end
    step();
    check_eq({tag, "_vld_early"}, data_valid, 1'b0);
    step();
  endtask

  initial begin
    #3;
    check_eq("rst_en", rnd_src_en, 1'b0);
    check_eq("rst_sel", rnd_src_sel, 2'd0);
    check_eq("rst_dout", data_out, 8'h00);
    check_eq("rst_vld", data_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stuck", stuck_err, 1'b0);
    #9 rst_n = 1'b1;
    step();

    // Basic word, div=0, consumer always ready
    cfg_sel = 2'd1;
    pulse_start();
    check_eq("basic_en", rnd_src_en, 1'b1);
    check_eq("basic_sel", rnd_src_sel, 2'd1);
    check_eq("basic_busy", busy, 1'b1);
    drive_word(8'hB2, "basic");
    check_eq("basic_vld", data_valid, 1'b1);
    check_eq("basic_dout", data_out, 8'hB2);
    step();
    check_eq("basic_vld_drop", data_valid, 1'b0);
    pulse_stop();

    // Divider of 2: last of 8 samples at start+4+24
    cfg_sample_div = 8'd2;
    rnd_src = 1'b1;
    pulse_start();
    for (int i = 0; i < 27; i++) step();
    check_eq("div_vld_early", data_valid, 1'b0);
    step();
    check_eq("div_vld", data_valid, 1'b1);
    check_eq("div_dout", data_out, 8'hFF);
    pulse_stop();
    cfg_sample_div = 8'd0;

    // Backpressure: word held 20 cycles, then next word timed from release
    data_ready = 1'b0;
    pulse_start();
    drive_word(8'hB2, "bp");
    rnd_src = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("bp_hold_vld", data_valid, 1'b1);
      check_eq("bp_hold_dout", data_out, 8'hB2);
    end
    data_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      rnd_src = (8'h5C >> (7 - k)) & 8'h01;
      step();
      if (k == 1) check_eq("bp_xfer_vld", data_valid, 1'b0);
    end
    step();
    check_eq("bp_next_early", data_valid, 1'b0);
    step();
    check_eq("bp_next_vld", data_valid, 1'b1);
    check_eq("bp_next_dout", data_out, 8'h5C);
    pulse_stop();

    // Stuck with rotation: 32 samples plus 3 transfer cycles after WARMUP
    rnd_src = 1'b0;
    cfg_sel = 2'd3;
    cfg_auto_rot = 1'b1;
    pulse_start();
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cyc++;
      if (stuck_err) break;
    end
    check_eq("rot_stuck", stuck_err, 1'b1);
    check_eq("rot_cycle", cyc, 39);
    check_eq("rot_sel", rnd_src_sel, 2'd0);
    check_eq("rot_en", rnd_src_en, 1'b1);
    check_eq("rot_busy", busy, 1'b1);
    check_eq("rot_vld", data_valid, 1'b0);
    drive_word(8'hB2, "rot");
    check_eq("rot_warm_vld", data_valid, 1'b1);
    check_eq("rot_warm_dout", data_out, 8'hB2);
    pulse_stop();

    // Stuck with halt
    rnd_src = 1'b0;
    cfg_sel = 2'd1;
    cfg_auto_rot = 1'b0;
    pulse_start();
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cyc++;
      if (stuck_err) break;
    end
    check_eq("halt_stuck", stuck_err, 1'b1);
    check_eq("halt_cycle", cyc, 39);
    check_eq("halt_busy", busy, 1'b0);
    check_eq("halt_en", rnd_src_en, 1'b0);
    check_eq("halt_sel", rnd_src_sel, 2'd1);
    for (int i = 0; i < 5; i++) step();
    check_eq("halt_sticky", stuck_err, 1'b1);
    pulse_start();
    check_eq("halt_clear", stuck_err, 1'b0);
    check_eq("halt_restart", busy, 1'b1);
    pulse_stop();

    // Stop while a word is pending
    data_ready = 1'b0;
    pulse_start();
    drive_word(8'h3C, "stop");
    check_eq("stop_pre_vld", data_valid, 1'b1);
    pulse_stop();
    check_eq("stop_vld", data_valid, 1'b0);
    check_eq("stop_en", rnd_src_en, 1'b0);
    check_eq("stop_busy", busy, 1'b0);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check_eq("stopstart_busy", busy, 1'b0);
    check_eq("stopstart_en", rnd_src_en, 1'b0);
    data_ready = 1'b1;

    // Scanmode mid-COLLECT
    pulse_start();
    for (int i = 0; i < 6; i++) step();
    scanmode = 1'b1;
    #1;
    check_eq("scan_en_comb", rnd_src_en, 1'b0);
    check_eq("scan_busy_pre", busy, 1'b1);
    step();
    check_eq("scan_idle", busy, 1'b0);
    pulse_start();
    check_eq("scan_start_ign", busy, 1'b0);
    scanmode = 1'b0;
    step();

    // Asynchronous reset mid-WARMUP
    cfg_sel = 2'd2;
    pulse_start();
    step();
    check_eq("arst_pre_sel", rnd_src_sel, 2'd2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_en", rnd_src_en, 1'b0);
    check_eq("arst_sel", rnd_src_sel, 2'd0);
    check_eq("arst_dout", data_out, 8'h00);
    check_eq("arst_vld", data_valid, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_stuck", stuck_err, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check_eq("arst_after_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
